seq_alu_bcd: RTL and testbench

Parametrised, multi-cycle successor to the 4-bit combinational ALU. It performs ADD, SUB, MULT, AND, OR and XOR on WIDTH-bit operands. MULT uses a sequential shift-add multiplier. Every result is converted to packed BCD by a sequential double-dabble engine, and a start/busy/done handshake controls each operation. It feeds the seven-segment display path and replaces the fixed 4-bit ALU wherever wider operands are needed.

---
 rtl/seq_alu_bcd_if.sv | 31 +++
 rtl/seq_alu_bcd.sv | 222 ++++++++++++++++++++++
 tb/tb_seq_alu_bcd.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_bcd_if.sv
// Bus bundle for seq_alu_bcd: operation request, captured operands and the
// registered result/status returned by the unit.
interface seq_alu_bcd_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      A;
    logic [WIDTH-1:0]      B;
    logic                  CarryIN;
    logic [2:0]            opCodeA;
    logic                  busy;
    logic                  done;
    logic [2*WIDTH-1:0]    result;
    logic [4*DIGITS-1:0]   bcd;
    logic                  CarryOUT;
    logic                  overflow;
    logic                  err;

    // Requester side: issues operations and observes results.
    modport master (
        output start, A, B, CarryIN, opCodeA,
        input  busy, done, result, bcd, CarryOUT, overflow, err
    );

    // ALU side: accepts operations and presents results.
    modport slave (
        input  start, A, B, CarryIN, opCodeA,
        output busy, done, result, bcd, CarryOUT, overflow, err
    );
endinterface

// File: rtl/seq_alu_bcd.sv
// Multi-cycle ALU with a sequential shift-add multiplier and a sequential
// double-dabble binary-to-BCD converter. Flow: IDLE -> EXEC -> CONV -> DONE.
module seq_alu_bcd #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_bcd_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW) + 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(RW - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_t;

    // One double-dabble step: correct every digit >= 5, then shift the
    // {bcd, binary} pair left by one bit.
    function automatic logic [BW+RW-1:0] dd_step(input logic [BW-1:0] bcd_in,
                                                 input logic [RW-1:0] bin_in);
        logic [BW-1:0] adj;
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj, bin_in} << 1;
    endfunction

    // Control state
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Captured operation
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [2:0]       op_q, op_d;
    // Multiplier and converter datapath
    logic [RW-1:0]    mcand_q, mcand_d, prod_q, prod_d;
    logic [BW-1:0]    cbcd_q, cbcd_d;
    logic [RW-1:0]    cbin_q, cbin_d, hold_q, hold_d;
    logic             hcout_q, hcout_d, hovf_q, hovf_d, herr_q, herr_d;
    // Output registers
    logic [RW-1:0]    result_q, result_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d;

    // Single-cycle ALU results for every opcode except MULT.
    logic [WIDTH:0]   sum_w, diff_w;
    logic [RW-1:0]    alu_res;
    logic             alu_c, alu_v, alu_e;
    logic [RW-1:0]    prod_nxt;
    logic [BW+RW-1:0] dd_nxt;

    // Combinational ALU, next multiplier partial product and next dabble step.
    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_w   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_e    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = RW'(sum_w);
                alu_c   = sum_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = RW'(diff_w[WIDTH-1:0]);
                alu_c   = diff_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = RW'(a_q & b_q);
            OP_OR:   alu_res = RW'(a_q | b_q);
            OP_XOR:  alu_res = RW'(a_q ^ b_q);
            OP_MULT: alu_res = '0;
            default: alu_e   = 1'b1;
        endcase
        prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);
        dd_nxt   = dd_step(cbcd_q, cbin_q);
    end

    // Next-state and datapath-update logic for the four-state sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cbcd_d   = cbcd_q;
        cbin_d   = cbin_q;
        hold_d   = hold_q;
        hcout_d  = hcout_q;
        hovf_d   = hovf_q;
        herr_d   = herr_q;
        result_d = result_q;
        bcd_d    = bcd_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    cin_d   = bus.CarryIN;
                    op_d    = bus.opCodeA;
                    mcand_d = RW'(bus.A);
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_MULT) begin
                    prod_d  = prod_nxt;
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == MULT_LAST) begin
                        cbin_d  = prod_nxt;
                        cbcd_d  = '0;
                        hold_d  = prod_nxt;
                        hcout_d = 1'b0;
                        hovf_d  = |prod_nxt[RW-1:WIDTH];
                        herr_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_CONV;
                    end
                end else begin
                    cbin_d  = alu_res;
                    cbcd_d  = '0;
                    hold_d  = alu_res;
                    hcout_d = alu_c;
                    hovf_d  = alu_v;
                    herr_d  = alu_e;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                cbcd_d = dd_nxt[BW+RW-1:RW];
                cbin_d = dd_nxt[RW-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CONV_LAST) begin
                    result_d = hold_q;
                    bcd_d    = dd_nxt[BW+RW-1:RW];
                    cout_d   = hcout_q;
                    ovf_d    = hovf_q;
                    err_d    = herr_q;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Control, status and output registers: cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            bcd_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            bcd_q    <= bcd_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Working datapath registers: always reloaded before use, so no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        cin_q   <= cin_d;
        op_q    <= op_d;
        mcand_q <= mcand_d;
        prod_q  <= prod_d;
        cbcd_q  <= cbcd_d;
        cbin_q  <= cbin_d;
        hold_q  <= hold_d;
        hcout_q <= hcout_d;
        hovf_q  <= hovf_d;
        herr_q  <= herr_d;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.bcd      = bcd_q;
    assign bus.CarryOUT = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_seq_alu_bcd.sv
// Bench for seq_alu_bcd: a WIDTH=4 and a WIDTH=8 instance, directed stimulus
// with hand-computed results, expectations queued and checked on done.
module tb_seq_alu_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_bcd_if #(.WIDTH(4), .DIGITS(3)) bus4();
    seq_alu_bcd_if #(.WIDTH(8), .DIGITS(5)) bus8();

    seq_alu_bcd #(.WIDTH(4), .DIGITS(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_alu_bcd #(.WIDTH(8), .DIGITS(5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [31:0] res;
        logic [31:0] bcd;
        logic        cout;
        logic        ovf;
        logic        err;
        int          dcyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor for the 4-bit unit.
    always @(negedge clk) begin
        if (!rst && bus4.done) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w4_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e4 = q4.pop_front();
                chk("w4_done_cycle", cyc, e4.dcyc);
                chk("w4_result",     32'(bus4.result), e4.res);
                chk("w4_bcd",        32'(bus4.bcd),    e4.bcd);
                chk("w4_carryout",   32'(bus4.CarryOUT), 32'(e4.cout));
                chk("w4_overflow",   32'(bus4.overflow), 32'(e4.ovf));
                chk("w4_err",        32'(bus4.err),      32'(e4.err));
            end
        end
    end

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        if (!rst && bus8.done) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("w8_done_cycle", cyc, e8.dcyc);
                chk("w8_result",     32'(bus8.result), e8.res);
                chk("w8_bcd",        32'(bus8.bcd),    e8.bcd);
                chk("w8_carryout",   32'(bus8.CarryOUT), 32'(e8.cout));
                chk("w8_overflow",   32'(bus8.overflow), 32'(e8.ovf));
                chk("w8_err",        32'(bus8.err),      32'(e8.err));
            end
        end
    end

    // Issue one operation on the 4-bit unit from a negedge while idle.
    // lat counts edges from the start edge (as 1) to the edge raising done.
    task automatic go4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [31:0] er, input logic [31:0] eb,
                       input logic ec, input logic ev, input logic ee, input int lat,
                       input bit push);
        exp_t e;
        bus4.start   = 1'b1;
        bus4.opCodeA = op;
        bus4.A       = a;
        bus4.B       = b;
        bus4.CarryIN = cin;
        @(negedge clk);
        bus4.start   = 1'b0;
        bus4.A       = ~a;
        bus4.B       = ~b;
        bus4.CarryIN = ~cin;
        bus4.opCodeA = 3'd0;
        e = '{er, eb, ec, ev, ee, cyc + lat - 1};
        if (push) q4.push_back(e);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (bus4.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL w4_idle_timeout: busy still %0b after %0d cycles, required 0", bus4.busy, n);
        end
    endtask

    initial begin
        int   bcount;
        int   s;
        exp_t eb2;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.CarryIN = 1'b0; bus4.opCodeA = '0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.CarryIN = 1'b0; bus8.opCodeA = '0;

        #1;
        chk("reset_result", 32'(bus4.result), 32'd0);
        chk("reset_bcd",    32'(bus4.bcd),    32'd0);
        chk("reset_flags",  {27'd0, bus4.CarryOUT, bus4.overflow, bus4.err, bus4.busy, bus4.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADD 15+15+1 = 31, carry out, no signed overflow
        go4(3'd0, 4'd15, 4'd15, 1'b1, 32'd31, 32'h031, 1'b1, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();
        // SUB 7-8 = -1 -> 15, borrow; 7 - (-8) = 15 does not fit signed
        go4(3'd1, 4'd7, 4'd8, 1'b0, 32'd15, 32'h015, 1'b1, 1'b1, 1'b0, 10, 1'b1);
        wait_idle4();
        // SUB 9-4-1 = 4, no borrow; signed -7 - 4 - 1 = -12 does not fit
        go4(3'd1, 4'd9, 4'd4, 1'b1, 32'd4, 32'h004, 1'b0, 1'b1, 1'b0, 10, 1'b1);
        wait_idle4();

        // MULT 15*15 = 225, upper half nonzero; busy for every cycle of the op
        go4(3'd2, 4'd15, 4'd15, 1'b1, 32'd225, 32'h225, 1'b0, 1'b1, 1'b0, 13, 1'b1);
        bcount = 0;
        while (bus4.busy && bcount < 200) begin
            bcount++;
            @(negedge clk);
        end
        chk("w4_mult_busy_cycles", bcount, 32'd13);

        // Logic operations
        go4(3'd4, 4'd14, 4'd3, 1'b1, 32'd2, 32'h002, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();
        go4(3'd6, 4'd15, 4'd15, 1'b1, 32'd0, 32'h000, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();
        go4(3'd5, 4'd10, 4'd5, 1'b0, 32'd15, 32'h015, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();

        // Illegal opcodes, then a legal ADD 2+3 clears err
        go4(3'd3, 4'd15, 4'd15, 1'b1, 32'd0, 32'h000, 1'b0, 1'b0, 1'b1, 10, 1'b1);
        wait_idle4();
        go4(3'd7, 4'd15, 4'd15, 1'b1, 32'd0, 32'h000, 1'b0, 1'b0, 1'b1, 10, 1'b1);
        wait_idle4();
        go4(3'd0, 4'd2, 4'd3, 1'b0, 32'd5, 32'h005, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();

        // MULT 12*13 = 156 with a stray start pulse mid-operation
        go4(3'd2, 4'd12, 4'd13, 1'b0, 32'd156, 32'h156, 1'b0, 1'b1, 1'b0, 13, 1'b1);
        repeat (3) @(negedge clk);
        bus4.start = 1'b1; bus4.opCodeA = 3'd0; bus4.A = 4'd1; bus4.B = 4'd1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_idle4();

        // Back-to-back with start held: ADD 6+7 = 13 (signed 6+7 overflows),
        // then XOR 5^3 = 6 captured at the first idle edge after done falls
        bus4.start = 1'b1; bus4.opCodeA = 3'd0; bus4.A = 4'd6; bus4.B = 4'd7; bus4.CarryIN = 1'b0;
        @(negedge clk);
        s = cyc;
        q4.push_back('{32'd13, 32'h013, 1'b0, 1'b1, 1'b0, s + 9});
        eb2 = '{32'd6, 32'h006, 1'b0, 1'b0, 1'b0, s + 11 + 9};
        q4.push_back(eb2);
        bus4.opCodeA = 3'd6; bus4.A = 4'd5; bus4.B = 4'd3;
        repeat (11) @(negedge clk);
        bus4.start = 1'b0;
        wait_idle4();

        // Reset during CONV aborts: outputs clear at once, no done
        go4(3'd0, 4'd1, 4'd1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_result", 32'(bus4.result), 32'd0);
        chk("rst_mid_bcd",    32'(bus4.bcd),    32'd0);
        chk("rst_mid_flags",  {27'd0, bus4.CarryOUT, bus4.overflow, bus4.err, bus4.busy, bus4.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        go4(3'd0, 4'd0, 4'd0, 1'b0, 32'd0, 32'h000, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        wait_idle4();

        // 8-bit unit: MULT 255*255 = 65025
        bus8.start = 1'b1; bus8.opCodeA = 3'd2; bus8.A = 8'd255; bus8.B = 8'd255; bus8.CarryIN = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0; bus8.A = 8'd0; bus8.B = 8'd0;
        q8.push_back('{32'd65025, 32'h65025, 1'b0, 1'b1, 1'b0, cyc + 24});
        bcount = 0;
        while (bus8.busy && bcount < 200) begin
            bcount++;
            @(negedge clk);
        end
        chk("w8_mult_busy_cycles", bcount, 32'd25);

        repeat (3) @(negedge clk);
        chk("w4_pending_expectations", q4.size(), 32'd0);
        chk("w8_pending_expectations", q8.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
